// File: rtl/ticket_barcode_reader.sv
// Ticket barcode reader: hunts for the frame start pattern in the serial bar
// stream, shifts in the client/duration/value payload, checks even parity and
// the stop bit, and presents a registered ticket record for every good frame.
module ticket_barcode_reader #(
  parameter logic [3:0] START_PAT = 4'b1011,
  parameter int         TIMEOUT   = 16,
  parameter int         CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             BarBit,
  input  logic             BarValid,
  output logic             TicketValid,
  output logic             ClientB,
  output logic [3:0]       Duration,
  output logic [4:0]       ValueToPay,
  output logic             ParityErr,
  output logic             FrameErr,
  output logic             Busy,
  output logic [CNT_W-1:0] GoodCount
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        window;
  logic [3:0]        window_next;
  logic [9:0]        payload;
  logic [3:0]        bit_cnt;
  logic              par_bit;
  logic [IDLE_W-1:0] idle_cnt;

  logic              start_hit;
  logic              timeout_hit;
  logic              frame_done;
  logic              parity_bad;
  logic              dur_onehot;
  logic              frame_bad;
  logic              pay_client;
  logic [3:0]        pay_dur;
  logic [4:0]        pay_val;

  assign window_next = {window[2:0], BarBit};
  assign pay_client  = payload[9];
  assign pay_dur     = payload[8:5];
  assign pay_val     = payload[4:0];
  assign parity_bad  = ^{payload, par_bit};
  assign dur_onehot  = (pay_dur != 4'd0) && ((pay_dur & (pay_dur - 4'd1)) == 4'd0);
  assign frame_bad   = BarBit | ~dur_onehot;
  assign Busy        = (state != HUNT);

  // Next-state decode; an idle timeout outside HUNT overrides everything.
  always_comb begin
    next_state  = state;
    start_hit   = 1'b0;
    timeout_hit = 1'b0;
    frame_done  = 1'b0;
    case (state)
      HUNT: begin
        if (BarValid && (window_next == START_PAT)) begin
          start_hit  = 1'b1;
          next_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (BarValid && (bit_cnt == 4'd9)) begin
          next_state = PARITY;
        end
      end
      PARITY: begin
        if (BarValid) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (BarValid) begin
          frame_done = 1'b1;
          next_state = HUNT;
        end
      end
      default: next_state = HUNT;
    endcase
    if ((state != HUNT) && !BarValid && (idle_cnt == IDLE_W'(TIMEOUT - 1))) begin
      timeout_hit = 1'b1;
      next_state  = HUNT;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= HUNT;
    end else begin
      state <= next_state;
    end
  end

  // Start window, payload shifter, bit counter and parity capture.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      window  <= 4'd0;
      payload <= 10'd0;
      bit_cnt <= 4'd0;
      par_bit <= 1'b0;
    end else begin
      if (state == HUNT && BarValid) begin
        window <= start_hit ? 4'd0 : window_next;
      end
      if (start_hit || frame_done || timeout_hit) begin
        bit_cnt <= 4'd0;
      end else if (state == PAYLOAD && BarValid) begin
        payload <= {payload[8:0], BarBit};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == PARITY && BarValid) begin
        par_bit <= BarBit;
      end
    end
  end

  // Idle timer: counts gaps between strobes inside a frame, parked at 0 in HUNT.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      idle_cnt <= '0;
    end else if (state == HUNT || BarValid || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Result pulses, held ticket fields and the saturating good-ticket counter.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      TicketValid <= 1'b0;
      ParityErr   <= 1'b0;
      FrameErr    <= 1'b0;
      ClientB     <= 1'b0;
      Duration    <= 4'd0;
      ValueToPay  <= 5'd0;
      GoodCount   <= '0;
    end else begin
      TicketValid <= 1'b0;
      ParityErr   <= 1'b0;
      FrameErr    <= 1'b0;
      if (timeout_hit) begin
        FrameErr <= 1'b1;
      end else if (frame_done) begin
        if (parity_bad) begin
          ParityErr <= 1'b1;
        end else if (frame_bad) begin
          FrameErr <= 1'b1;
        end else begin
          TicketValid <= 1'b1;
          ClientB     <= pay_client;
          Duration    <= pay_dur;
          ValueToPay  <= pay_val;
          if (GoodCount != '1) begin
            GoodCount <= GoodCount + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ticket_barcode_reader.sv
// Bench for ticket_barcode_reader: frames are built from fields, the expected
// result is pushed to a scoreboard at the stop bit, and a monitor pops and
// compares whenever a result pulse appears.
module tb_ticket_barcode_reader;

  localparam int CNT_W = 8;

  logic             Clk = 1'b0;
  logic             ResetN;
  logic             BarBit;
  logic             BarValid;
  logic             TicketValid;
  logic             ClientB;
  logic [3:0]       Duration;
  logic [4:0]       ValueToPay;
  logic             ParityErr;
  logic             FrameErr;
  logic             Busy;
  logic [CNT_W-1:0] GoodCount;

  ticket_barcode_reader #(
    .START_PAT(4'b1011),
    .TIMEOUT  (16),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .BarBit     (BarBit),
    .BarValid   (BarValid),
    .TicketValid(TicketValid),
    .ClientB    (ClientB),
    .Duration   (Duration),
    .ValueToPay (ValueToPay),
    .ParityErr  (ParityErr),
    .FrameErr   (FrameErr),
    .Busy       (Busy),
    .GoodCount  (GoodCount)
  );

  always #5 Clk = ~Clk;

  // kind is {TicketValid, ParityErr, FrameErr}
  typedef struct {
    logic [2:0]       kind;
    logic             client;
    logic [3:0]       dur;
    logic [4:0]       val;
    logic [CNT_W-1:0] count;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  logic             m_client;
  logic [3:0]       m_dur;
  logic [4:0]       m_val;
  logic [CNT_W-1:0] m_count;

  // Cycle counter used to check result latency.
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int gap);
    @(negedge Clk);
    BarBit   = b;
    BarValid = 1'b1;
    repeat (gap) begin
      @(negedge Clk);
      BarValid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      BarValid = 1'b0;
    end
  endtask

  function automatic exp_t held_expect(input logic [2:0] kind);
    exp_t e;
    e.kind   = kind;
    e.client = m_client;
    e.dur    = m_dur;
    e.val    = m_val;
    e.count  = m_count;
    e.cyc    = 0;
    return e;
  endfunction

  // Sends one complete frame; gaps of up to max_gap idle cycles between bits.
  task automatic apply_stimulus(input logic client, input logic [3:0] dur, input logic [4:0] val,
                                input logic p, input logic stop, input int max_gap);
    logic [15:0] frame;
    logic [2:0]  kind;
    exp_t        e;
    frame = {4'b1011, client, dur, val, p, stop};
    if (^{client, dur, val, p}) begin
      kind = 3'b010;
    end else if (stop || ($countones(dur) != 1)) begin
      kind = 3'b001;
    end else begin
      kind     = 3'b100;
      m_client = client;
      m_dur    = dur;
      m_val    = val;
      if (m_count != {CNT_W{1'b1}}) m_count = m_count + 1'b1;
    end
    e = held_expect(kind);
    for (int i = 15; i >= 1; i--) begin
      drive_bit(frame[i], int'($urandom_range(0, max_gap)));
    end
    @(negedge Clk);
    BarBit   = frame[0];
    BarValid = 1'b1;
    e.cyc    = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: every result pulse is matched against the oldest expectation.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (ResetN === 1'b1 && (TicketValid || ParityErr || FrameErr)) begin
      if (sb.size() == 0) begin
        check_output("unexpected_pulse", {29'd0, TicketValid, ParityErr, FrameErr}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("result_kind", {29'd0, TicketValid, ParityErr, FrameErr}, {29'd0, e.kind});
        check_output("result_latency", cyc, e.cyc);
        check_output("client_b", ClientB, e.client);
        check_output("duration", Duration, e.dur);
        check_output("value_to_pay", ValueToPay, e.val);
        check_output("good_count", GoodCount, e.count);
        check_output("busy_after_result", Busy, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  noise;
    logic [9:0]  part;
    logic        c;
    logic [3:0]  d;
    logic [4:0]  v;
    exp_t        e;

    ResetN   = 1'b0;
    BarBit   = 1'b0;
    BarValid = 1'b0;
    m_client = 1'b0;
    m_dur    = 4'd0;
    m_val    = 5'd0;
    m_count  = '0;

    #1;
    check_output("reset_pulses", {29'd0, TicketValid, ParityErr, FrameErr}, 32'd0);
    check_output("reset_fields", {ClientB, Duration, ValueToPay}, 32'd0);
    check_output("reset_busy", Busy, 1'b0);
    check_output("reset_count", GoodCount, 32'd0);
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    idle(2);

    $display("[TB] good frame, client A, 2 h, value 8");
    apply_stimulus(1'b0, 4'b0100, 5'b01000, 1'b0, 1'b0, 0);
    idle(3);

    $display("[TB] same frame with wrong parity");
    apply_stimulus(1'b0, 4'b0100, 5'b01000, 1'b1, 1'b0, 0);
    idle(3);

    $display("[TB] client B, 1 h, value 4: bad stop bit then good");
    apply_stimulus(1'b1, 4'b0010, 5'b00100, 1'b1, 1'b1, 0);
    idle(3);
    apply_stimulus(1'b1, 4'b0010, 5'b00100, 1'b1, 1'b0, 0);
    idle(3);

    $display("[TB] non-one-hot duration");
    apply_stimulus(1'b0, 4'b0110, 5'b00011, 1'b0, 1'b0, 0);
    idle(3);

    $display("[TB] zero duration");
    apply_stimulus(1'b1, 4'b0000, 5'b00001, 1'b0, 1'b0, 0);
    idle(3);

    $display("[TB] leading noise with near-miss start window");
    noise = 8'b11010011;
    for (int i = 7; i >= 0; i--) drive_bit(noise[i], 0);
    apply_stimulus(1'b1, 4'b0001, 5'b10101, 1'b1, 1'b0, 0);
    idle(3);

    $display("[TB] sparse strobes");
    apply_stimulus(1'b1, 4'b0100, 5'b11111, 1'b1, 1'b0, 3);
    idle(3);
    apply_stimulus(1'b0, 4'b0001, 5'b10010, 1'b1, 1'b0, 5);
    idle(3);

    $display("[TB] idle timeout after 6 payload bits");
    part = {4'b1011, 6'b100101};
    for (int i = 9; i >= 0; i--) drive_bit(part[i], 0);
    @(negedge Clk);
    BarValid = 1'b0;
    e = held_expect(3'b001);
    e.cyc = cyc + 16;
    sb.push_back(e);
    check_output("busy_in_frame", Busy, 1'b1);
    idle(20);
    check_output("busy_after_timeout", Busy, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 5'b00001, 1'b0, 1'b0, 0);
    idle(3);

    $display("[TB] reset in the middle of a frame");
    part = {4'b1011, 6'b101000};
    for (int i = 9; i >= 0; i--) drive_bit(part[i], 0);
    @(negedge Clk);
    ResetN   = 1'b0;
    BarValid = 1'b0;
    #1;
    check_output("midreset_pulses", {29'd0, TicketValid, ParityErr, FrameErr}, 32'd0);
    check_output("midreset_fields", {ClientB, Duration, ValueToPay}, 32'd0);
    check_output("midreset_busy", Busy, 1'b0);
    check_output("midreset_count", GoodCount, 32'd0);
    check_output("midreset_pending", sb.size(), 32'd0);
    m_client = 1'b0;
    m_dur    = 4'd0;
    m_val    = 5'd0;
    m_count  = '0;
    idle(2);
    @(negedge Clk);
    ResetN = 1'b1;
    idle(5);

    $display("[TB] counter saturation over 260 good frames");
    for (int k = 0; k < 260; k++) begin
      c = 1'($urandom_range(0, 1));
      d = 4'b0001 << $urandom_range(0, 2);
      v = 5'($urandom_range(0, 31));
      apply_stimulus(c, d, v, ^{c, d, v}, 1'b0, (k % 8 == 0) ? 2 : 0);
    end
    idle(3);
    check_output("good_count_saturated", GoodCount, 32'd255);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge Clk);
    if (sb.size() != 0) check_output("scoreboard_drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
